// File: rtl/clken_pkg.sv
// Shared FSM state type and default sizing for the clock-enable generator.
package clken_pkg;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam int unsigned ACC_W_DEF    = 32;
  localparam int unsigned LOCK_DLY_DEF = 16;
  // Lock counter width; LOCK_DLY never exceeds 255.
  localparam int unsigned CNT_W        = 8;

endpackage

// File: rtl/clken_acc.sv
// One channel: increment register, phase accumulator, carry-out enable pulse
// and square-wave output.
module clken_acc #(
  parameter int unsigned      ACC_W = 8,
  parameter logic [ACC_W-1:0] INIT  = '0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic             ld,
  input  logic [ACC_W-1:0] ld_inc,
  output logic             clk_en,
  output logic             clk_sq
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] inc_q;
  logic [ACC_W:0]   sum;

  // Extra top bit of the sum is the carry that fires the enable.
  assign sum    = {1'b0, acc_q} + {1'b0, inc_q};
  assign clk_sq = acc_q[ACC_W-1];

  // Accumulate while running; a clear wins over accumulation.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      inc_q  <= INIT;
      acc_q  <= '0;
      clk_en <= 1'b0;
    end else begin
      if (ld) begin
        inc_q <= ld_inc;
      end
      if (clr) begin
        acc_q  <= '0;
        clk_en <= 1'b0;
      end else if (run) begin
        acc_q  <= sum[ACC_W-1:0];
        clk_en <= sum[ACC_W];
      end else begin
        clk_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clken_gen.sv
// Multi-channel phase-accumulator clock-enable generator with a lock
// delay after reset or reconfiguration and a phase-realign request.
module clken_gen
  import clken_pkg::*;
#(
  parameter int unsigned               NUM_CH   = 2,
  parameter int unsigned               ACC_W    = ACC_W_DEF,
  parameter int unsigned               LOCK_DLY = LOCK_DLY_DEF,
  parameter logic [NUM_CH*ACC_W-1:0]   INIT_INC = '0,
  localparam int unsigned              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_ready,
  input  logic              resync,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_sq,
  output logic              locked
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_d;
  logic             ch_ok;
  logic             wr;
  logic             run;
  logic             clr;

  // Writes to channel numbers the build does not have are dropped.
  generate
    if ((2 ** CH_W) > NUM_CH) begin : g_ch_chk
      assign ch_ok = (32'(cfg_ch) < NUM_CH);
    end else begin : g_ch_all
      assign ch_ok = 1'b1;
    end
  endgenerate

  assign wr  = cfg_valid && cfg_ready && ch_ok;
  assign run = (state_q == ST_LOCK);
  assign clr = wr || ((state_q == ST_LOCK) && resync);

  // State, lock counter and registered status outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_WAIT;
      cnt_q     <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      locked    <= locked_d;
      cfg_ready <= 1'b1;
    end
  end

  // Next state: a write restarts the lock wait from either state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    locked_d = locked;
    if (wr) begin
      state_d  = ST_WAIT;
      cnt_d    = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          locked_d = 1'b0;
          if (cnt_q == CNT_W'(LOCK_DLY - 1)) begin
            state_d = ST_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_LOCK: begin
          locked_d = 1'b1;
        end
        default: begin
          state_d  = ST_WAIT;
          cnt_d    = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // One accumulator per channel.
  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      clken_acc #(
        .ACC_W (ACC_W),
        .INIT  (INIT_INC[k*ACC_W +: ACC_W])
      ) u_acc (
        .refclk (refclk),
        .rst    (rst),
        .run    (run),
        .clr    (clr),
        .ld     (wr && (cfg_ch == CH_W'(k))),
        .ld_inc (cfg_inc),
        .clk_en (clk_en[k]),
        .clk_sq (clk_sq[k])
      );
    end
  endgenerate

endmodule
